// File: rtl/event_serializer_if.sv
// Event FIFO read side and RPi output FIFO write side of event_serializer.
// master = serializer (pops events, pushes words); slave = the two FIFOs.
interface event_serializer_if #(
    parameter int unsigned EV_W  = 256,
    parameter int unsigned OUT_W = 16
);
    logic             ev_empty;
    logic             ev_rd_en;
    logic [EV_W-1:0]  ev_data;
    logic             out_full;
    logic             out_wr_en;
    logic [OUT_W-1:0] out_data;

    modport master (
        input  ev_empty, ev_data, out_full,
        output ev_rd_en, out_wr_en, out_data
    );

    modport slave (
        output ev_empty, ev_data, out_full,
        input  ev_rd_en, out_wr_en, out_data
    );
endinterface

// File: rtl/event_serializer.sv
// Pops 32-tube drift-time records and writes a header plus tagged per-tube words to the RPi FIFO.
// Optional macro ZERO_SUPPRESS_EN: tubes reading NO_HIT are skipped (cycle still spent, no write).
module event_serializer #(
    parameter int unsigned       NUM_TUBES = 32,
    parameter int unsigned       TIME_W    = 8,
    parameter logic [TIME_W-1:0] NO_HIT    = 8'hFF
) (
    input  logic               clk100,
    input  logic               rst_n,
    event_serializer_if.master bus,
    output logic               busy,
    output logic [7:0]         evt_seq
);

    localparam int unsigned   IDX_W    = $clog2(NUM_TUBES);
    localparam int unsigned   REC_W    = NUM_TUBES * TIME_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StHdr, StEmit} state_e;

    state_e             r_state, w_state_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic [7:0]         r_seq, w_seq_d;
    logic [REC_W-1:0]   r_shadow, w_shadow_d;
    logic [6:0]         r_hit_cnt, w_hit_cnt_d;
    logic [6:0]         w_hit_cnt;
    logic [TIME_W-1:0]  w_time;
    logic               w_emit_en;
    logic               w_pending;
    logic               w_rd_en;
    logic [15:0]        w_word;

    // Tube 0 lives in the MSBs of the record.
    assign w_time = r_shadow[(NUM_TUBES - 1 - 32'(r_idx)) * TIME_W +: TIME_W];

`ifdef ZERO_SUPPRESS_EN
    assign w_emit_en = (w_time != NO_HIT);
`else
    assign w_emit_en = 1'b1;
`endif

    always_comb begin
        w_hit_cnt = '0;
        for (int k = 0; k < NUM_TUBES; k++) begin
            if (bus.ev_data[k*TIME_W +: TIME_W] != NO_HIT) begin
                w_hit_cnt = w_hit_cnt + 7'd1;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_seq_d     = r_seq;
        w_shadow_d  = r_shadow;
        w_hit_cnt_d = r_hit_cnt;
        w_rd_en     = 1'b0;
        w_pending   = 1'b0;
        w_word      = '0;
        unique case (r_state)
            StIdle: begin
                if (!bus.ev_empty) begin
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                w_rd_en   = 1'b1;
                w_state_d = StLoad;
            end
            StLoad: begin
                w_shadow_d  = bus.ev_data;
                w_hit_cnt_d = w_hit_cnt;
                w_state_d   = StHdr;
            end
            StHdr: begin
                w_pending = 1'b1;
                w_word    = {1'b1, r_hit_cnt, r_seq};
                if (!bus.out_full) begin
                    w_idx_d   = '0;
                    w_state_d = StEmit;
                end
            end
            StEmit: begin
                w_pending = w_emit_en;
                if (w_emit_en) begin
                    w_word = {1'b0, r_idx, 2'b00, w_time};
                end
                // Skipped tubes never wait on out_full.
                if (!w_emit_en || !bus.out_full) begin
                    w_idx_d = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_seq_d   = r_seq + 8'd1;
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_seq     <= '0;
            r_shadow  <= '1;
            r_hit_cnt <= '0;
        end else begin
            r_idx     <= w_idx_d;
            r_seq     <= w_seq_d;
            r_shadow  <= w_shadow_d;
            r_hit_cnt <= w_hit_cnt_d;
        end
    end

    assign bus.ev_rd_en  = w_rd_en;
    assign bus.out_wr_en = w_pending && !bus.out_full;
    assign bus.out_data  = w_word;
    assign busy          = (r_state != StIdle);
    assign evt_seq       = r_seq;

endmodule

// File: tb/tb_event_serializer.sv
// Directed bench for event_serializer: event FIFO model, output word capture, per-scenario tasks.
module tb_event_serializer;

    logic       clk100 = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] evt_seq;

    event_serializer_if bus ();

    event_serializer dut (
        .clk100  (clk100),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .evt_seq (evt_seq)
    );

    always #5 clk100 = ~clk100;

    int           n_total = 0;
    int           n_bad   = 0;
    int           cyc     = 0;
    int           idle_cyc = 0;
    logic         busy_prev = 1'b0;
    logic [255:0] ev_mem [0:511];
    int           ev_wp = 0;
    int           ev_rp = 0;
    logic [15:0]  wr_q [$];
    int           rd_cyc_q [$];

    always @(posedge clk100) cyc <= cyc + 1;

    // Event FIFO model and output capture, all away from the active edge.
    always @(negedge clk100) begin
        if (bus.out_wr_en) wr_q.push_back(bus.out_data);
        if (bus.ev_rd_en) begin
            rd_cyc_q.push_back(cyc);
            if (ev_rp != ev_wp) begin
                bus.ev_data = ev_mem[ev_rp];
                ev_rp = ev_rp + 1;
            end
        end
        bus.ev_empty = (ev_rp == ev_wp);
        if (busy_prev && !busy) idle_cyc = cyc;
        busy_prev = busy;
    end

    function automatic logic [255:0] ev_fill(input logic [7:0] t);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[(31-k)*8 +: 8] = t;
        return v;
    endfunction

    task automatic push_ev(input logic [255:0] ev);
        ev_mem[ev_wp] = ev;
        ev_wp = ev_wp + 1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(posedge clk100);
            #1;
            n++;
        end while (!((ev_rp == ev_wp) && !busy) && n < budget);
        @(negedge clk100);
        #1;
        n_total++;
        if (!((ev_rp == ev_wp) && !busy)) begin
            n_bad++;
            $display("FAIL %s timeout: busy=%0b queued=%0d, required idle within %0d cycles",
                     name, busy, ev_wp - ev_rp, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_full = 1'b0;
        repeat (3) @(posedge clk100);
        #1;
        n_total++;
        if (bus.out_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL reset out_wr_en: got %b want 0", bus.out_wr_en);
        end
        n_total++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_total++;
        if (evt_seq !== 8'd0) begin n_bad++; $display("FAIL reset evt_seq: got %h want 00", evt_seq); end
        n_total++;
        if (bus.ev_rd_en !== 1'b0) begin
            n_bad++; $display("FAIL reset ev_rd_en: got %b want 0", bus.ev_rd_en);
        end
        n_total++;
        if (bus.out_data !== 16'h0000) begin
            n_bad++; $display("FAIL reset out_data: got %h want 0000", bus.out_data);
        end
        rst_n = 1'b1;
        @(posedge clk100);
        #1;
    endtask

    task automatic test_sparse();
        logic [255:0] ev;
        logic [15:0]  exp [$];
        int           base, rbase, got_n;
        logic [4:0]   kk;
        ev = ev_fill(8'hFF);
        ev[255 -: 8] = 8'h12;
        ev[7:0]      = 8'h34;
`ifdef ZERO_SUPPRESS_EN
        exp = '{16'h8200, 16'h0012, 16'h7C34};
`else
        exp.push_back(16'h8200);
        for (int k = 0; k < 32; k++) begin
            kk = 5'(k);
            if (k == 0) exp.push_back(16'h0012);
            else if (k == 31) exp.push_back(16'h7C34);
            else exp.push_back({1'b0, kk, 2'b00, 8'hFF});
        end
`endif
        base  = wr_q.size();
        rbase = rd_cyc_q.size();
        push_ev(ev);
        wait_idle(200, "sparse");
        got_n = wr_q.size() - base;
        n_total++;
        if (got_n != exp.size()) begin
            n_bad++; $display("FAIL sparse count: got %0d want %0d", got_n, exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_n; i++) begin
            n_total++;
            if (wr_q[base+i] !== exp[i]) begin
                n_bad++; $display("FAIL sparse word %0d: got %h want %h", i, wr_q[base+i], exp[i]);
            end
        end
        n_total++;
        if (evt_seq !== 8'd1) begin n_bad++; $display("FAIL sparse evt_seq: got %h want 01", evt_seq); end
        n_total++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL sparse busy: got %b want 0", busy); end
        n_total++;
        if (rd_cyc_q.size() - rbase != 1) begin
            n_bad++; $display("FAIL sparse rd pulses: got %0d want 1", rd_cyc_q.size() - rbase);
        end else begin
            n_total++;
            if (idle_cyc - rd_cyc_q[rbase] != 35) begin
                n_bad++;
                $display("FAIL sparse fetch-to-idle: got %0d want 35", idle_cyc - rd_cyc_q[rbase]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] ev;
        logic [15:0]  exp [$];
        int           base, got_n;
        logic [4:0]   kk;
        bit           found;
        ev = ev_fill(8'hFF);
        ev[(31-5)*8 +: 8] = 8'h40;
`ifdef ZERO_SUPPRESS_EN
        exp = '{16'h8101, 16'h1440};
`else
        exp.push_back(16'h8101);
        for (int k = 0; k < 32; k++) begin
            kk = 5'(k);
            exp.push_back((k == 5) ? 16'h1440 : {1'b0, kk, 2'b00, 8'hFF});
        end
`endif
        base = wr_q.size();
        push_ev(ev);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk100);
            #1;
            if (bus.out_wr_en && bus.out_data == 16'h1440) found = 1'b1;
        end
        n_total++;
        if (!found) begin
            n_bad++; $display("FAIL bp reach idx5: got no 1440 word want one within 100 cycles");
        end else begin
            bus.out_full = 1'b1;
            repeat (10) begin
                #1;
                n_total++;
                if (bus.out_wr_en !== 1'b0) begin
                    n_bad++; $display("FAIL bp stall wr_en: got %b want 0", bus.out_wr_en);
                end
                n_total++;
                if (bus.out_data !== 16'h1440) begin
                    n_bad++; $display("FAIL bp stall data: got %h want 1440", bus.out_data);
                end
                @(posedge clk100);
            end
            #1;
            bus.out_full = 1'b0;
        end
        wait_idle(200, "bp");
        got_n = wr_q.size() - base;
        n_total++;
        if (got_n != exp.size()) begin
            n_bad++; $display("FAIL bp count: got %0d want %0d", got_n, exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_n; i++) begin
            n_total++;
            if (wr_q[base+i] !== exp[i]) begin
                n_bad++; $display("FAIL bp word %0d: got %h want %h", i, wr_q[base+i], exp[i]);
            end
        end
        n_total++;
        if (evt_seq !== 8'd2) begin n_bad++; $display("FAIL bp evt_seq: got %h want 02", evt_seq); end
    endtask

    task automatic test_reset_mid_event();
        logic [255:0] ev;
        bit           found;
        for (int k = 0; k < 32; k++) ev[(31-k)*8 +: 8] = 8'(k);
        push_ev(ev);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk100);
            #1;
            if (bus.out_wr_en && bus.out_data == 16'h280A) found = 1'b1;
        end
        n_total++;
        if (!found) begin
            n_bad++; $display("FAIL midrst reach idx10: got no 280A word want one within 100 cycles");
        end
        rst_n = 1'b0;
        @(posedge clk100);
        #1;
        rst_n = 1'b1;
        n_total++;
        if (bus.out_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL midrst out_wr_en: got %b want 0", bus.out_wr_en);
        end
        n_total++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst busy: got %b want 0", busy); end
        n_total++;
        if (evt_seq !== 8'd0) begin n_bad++; $display("FAIL midrst evt_seq: got %h want 00", evt_seq); end
    endtask

    task automatic test_all_hit();
        logic [255:0] ev;
        logic [15:0]  exp [$];
        int           base, got_n;
        logic [4:0]   kk;
        logic [7:0]   tt;
        exp.push_back(16'hA000);
        for (int k = 0; k < 32; k++) begin
            ev[(31-k)*8 +: 8] = 8'(k);
            kk = 5'(k);
            tt = 8'(k);
            exp.push_back({1'b0, kk, 2'b00, tt});
        end
        base = wr_q.size();
        push_ev(ev);
        wait_idle(200, "allhit");
        got_n = wr_q.size() - base;
        n_total++;
        if (got_n != exp.size()) begin
            n_bad++; $display("FAIL allhit count: got %0d want %0d", got_n, exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_n; i++) begin
            n_total++;
            if (wr_q[base+i] !== exp[i]) begin
                n_bad++; $display("FAIL allhit word %0d: got %h want %h", i, wr_q[base+i], exp[i]);
            end
        end
        n_total++;
        if (evt_seq !== 8'd1) begin n_bad++; $display("FAIL allhit evt_seq: got %h want 01", evt_seq); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] hdr [$];
        logic [7:0]  sq;
        int          base, rbase, got_n, want_n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk100);
        #1;
        rst_n = 1'b1;
        base  = wr_q.size();
        rbase = rd_cyc_q.size();
        for (int e = 0; e < 257; e++) push_ev(ev_fill(8'hFF));
        wait_idle(257 * 36 + 100, "b2b");
        got_n = wr_q.size() - base;
`ifdef ZERO_SUPPRESS_EN
        want_n = 257;
`else
        want_n = 257 * 33;
`endif
        n_total++;
        if (got_n != want_n) begin
            n_bad++; $display("FAIL b2b write count: got %0d want %0d", got_n, want_n);
        end
        for (int i = 0; i < got_n; i++) if (wr_q[base+i][15]) hdr.push_back(wr_q[base+i]);
        n_total++;
        if (hdr.size() != 257) begin
            n_bad++; $display("FAIL b2b header count: got %0d want 257", hdr.size());
        end
        for (int i = 0; i < hdr.size() && i < 257; i++) begin
            sq = 8'(i);
            n_total++;
            if (hdr[i] !== {8'h80, sq}) begin
                n_bad++; $display("FAIL b2b header %0d: got %h want %h", i, hdr[i], {8'h80, sq});
            end
        end
        n_total++;
        if (rd_cyc_q.size() - rbase != 257) begin
            n_bad++; $display("FAIL b2b rd pulses: got %0d want 257", rd_cyc_q.size() - rbase);
        end
        for (int i = rbase + 1; i < rd_cyc_q.size(); i++) begin
            n_total++;
            if (rd_cyc_q[i] - rd_cyc_q[i-1] != 36) begin
                n_bad++;
                $display("FAIL b2b spacing %0d: got %0d want 36", i - rbase, rd_cyc_q[i] - rd_cyc_q[i-1]);
            end
        end
        n_total++;
        if (evt_seq !== 8'd1) begin n_bad++; $display("FAIL b2b evt_seq: got %h want 01", evt_seq); end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_backpressure();
        test_reset_mid_event();
        test_all_hit();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
